// File: rtl/tdm_demux8.sv
// tdm_demux8: receive end of an 8:1 time-division link.
// Tracks the slot index, collects one W-bit sample per slot into a shadow
// register and publishes a complete 8-channel frame on a registered bus.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   en          slot strobe; one slot consumed per cycle with en=1
//   D           serial slot data (channel i carried in slot i)
//   frame_sync  marks the slot-0 cycle; qualified by en
//   O           frame output; channel i at O[i*W +: W]
//   frame_valid one-cycle pulse: O holds a newly completed frame
//   S           current expected slot index
//   locked      frame alignment acquired
//   sync_err    one-cycle pulse: frame_sync arrived mid-frame
module tdm_demux8 #(
   parameter int unsigned W = 1
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           en,
   input  logic [W-1:0]   D,
   input  logic           frame_sync,
   output logic [8*W-1:0] O,
   output logic           frame_valid,
   output logic [2:0]     S,
   output logic           locked,
   output logic           sync_err
);

   typedef enum logic [0:0] {StUnlocked, StLocked} state_e;

   state_e         state_q, state_d;
   logic [2:0]     s_q, s_d;
   // Slot 7 is never stored: it goes straight from D into the published frame.
   logic [7*W-1:0] shadow_q, shadow_d;
   logic [8*W-1:0] o_q, o_d;
   logic           fv_q, fv_d;
   logic           se_q, se_d;

   always_comb begin
      state_d  = state_q;
      s_d      = s_q;
      shadow_d = shadow_q;
      o_d      = o_q;
      fv_d     = 1'b0;
      se_d     = 1'b0;
      if (en) begin
         unique case (state_q)
            StUnlocked: begin
               if (frame_sync) begin
                  shadow_d[W-1:0] = D;
                  s_d             = 3'd1;
                  state_d         = StLocked;
               end
            end
            StLocked: begin
               if (frame_sync && (s_q != 3'd0)) begin
                  // Misaligned sync: drop the partial frame and restart at slot 1.
                  se_d            = 1'b1;
                  shadow_d[W-1:0] = D;
                  s_d             = 3'd1;
               end else if (s_q == 3'd7) begin
                  o_d  = {D, shadow_q};
                  fv_d = 1'b1;
                  s_d  = 3'd0;
               end else begin
                  shadow_d[int'(s_q)*W +: W] = D;
                  s_d                        = s_q + 3'd1;
               end
            end
            default: state_d = StUnlocked;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StUnlocked;
         s_q      <= 3'd0;
         shadow_q <= '0;
         o_q      <= '0;
         fv_q     <= 1'b0;
         se_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         s_q      <= s_d;
         shadow_q <= shadow_d;
         o_q      <= o_d;
         fv_q     <= fv_d;
         se_q     <= se_d;
      end
   end

   assign O           = o_q;
   assign frame_valid = fv_q;
   assign S           = s_q;
   assign locked      = (state_q == StLocked);
   assign sync_err    = se_q;

endmodule

// File: tb/tb_tdm_demux8.sv
// Bench for tdm_demux8: two instances (W=1 and W=4) share en/frame_sync/rst_n;
// the W=1 instance sees bit 0 of the W=4 slot data. A queue-based frame model
// predicts every output after each clock edge.
module tb_tdm_demux8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic        frame_sync = 1'b0;
   logic [3:0]  d4 = 4'h0;
   logic [0:0]  d1;
   logic [7:0]  o1;
   logic [31:0] o4;
   logic [2:0]  s1, s4;
   logic        fv1, fv4, lk1, lk4, se1, se4;

   assign d1 = d4[0];

   always #5 clk = ~clk;

   tdm_demux8 #(.W(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .en(en), .D(d1), .frame_sync(frame_sync),
      .O(o1), .frame_valid(fv1), .S(s1), .locked(lk1), .sync_err(se1)
   );

   tdm_demux8 #(.W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .en(en), .D(d4), .frame_sync(frame_sync),
      .O(o4), .frame_valid(fv4), .S(s4), .locked(lk4), .sync_err(se4)
   );

   // Reference model: samples of the frame in progress, in arrival order.
   logic [3:0]  m_q[$];
   logic        m_locked;
   logic [31:0] m_o;
   logic        m_fv, m_se;

   int vectors = 0;
   int miscompares = 0;

   task automatic model_reset();
      m_q.delete();
      m_locked = 1'b0;
      m_o      = '0;
      m_fv     = 1'b0;
      m_se     = 1'b0;
   endtask

   task automatic model_step(input logic e, input logic fs, input logic [3:0] d);
      m_fv = 1'b0;
      m_se = 1'b0;
      if (e) begin
         if (fs) begin
            if (m_locked && m_q.size() != 0) m_se = 1'b1;
            m_q.delete();
            m_q.push_back(d);
            m_locked = 1'b1;
         end else if (m_locked) begin
            m_q.push_back(d);
            if (m_q.size() == 8) begin
               for (int i = 0; i < 8; i++) m_o[i*4 +: 4] = m_q[i];
               m_fv = 1'b1;
               m_q.delete();
            end
         end
      end
   endtask

   function automatic logic [51:0] exp_vec();
      logic [7:0] e1;
      logic [2:0] es;
      for (int i = 0; i < 8; i++) e1[i] = m_o[i*4];
      es = 3'(m_q.size());
      return {m_o, e1, es, es, m_locked, m_locked, m_fv, m_fv, m_se, m_se};
   endfunction

   function automatic logic [51:0] obs_vec();
      return {o4, o1, s4, s1, lk4, lk1, fv4, fv1, se4, se1};
   endfunction

   // Drive one cycle of inputs at the falling edge, then sample 1 after the rising edge.
   task automatic cyc(input logic e, input logic fs, input logic [3:0] d);
      @(negedge clk);
      en = e;
      frame_sync = fs;
      d4 = d;
      @(posedge clk);
      model_step(e, fs, d);
      #1;
   endtask

   task automatic test_reset();
      model_reset();
      #2;
      vectors++;
      if (obs_vec() !== exp_vec()) begin
         $display("FAIL reset_state: got %h want %h", obs_vec(), exp_vec());
         miscompares++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         cyc(1'b1, 1'b0, 4'h1);
         vectors++;
         if (obs_vec() !== exp_vec()) begin
            $display("FAIL idle_unlocked[%0d]: got %h want %h", i, obs_vec(), exp_vec());
            miscompares++;
         end
      end
   endtask

   task automatic test_basic();
      logic [3:0] seq [8] = '{4'h1, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h1, 4'h0};
      for (int i = 0; i < 8; i++) begin
         cyc(1'b1, (i == 0), seq[i]);
         vectors++;
         if (obs_vec() !== exp_vec()) begin
            $display("FAIL basic_frame[%0d]: got %h want %h", i, obs_vec(), exp_vec());
            miscompares++;
         end
      end
      vectors++;
      if ({o1, fv1, s1, lk1} !== {8'b0100_1101, 1'b1, 3'd0, 1'b1}) begin
         $display("FAIL basic_publish: got o=%b fv=%b s=%0d lk=%b want o=01001101 fv=1 s=0 lk=1",
                  o1, fv1, s1, lk1);
         miscompares++;
      end
      cyc(1'b0, 1'b0, 4'h0);
      vectors++;
      if (obs_vec() !== exp_vec()) begin
         $display("FAIL basic_pulse_end: got %h want %h", obs_vec(), exp_vec());
         miscompares++;
      end
   endtask

   task automatic test_flywheel();
      for (int i = 0; i < 8; i++) begin
         cyc(1'b1, (i == 0), 4'($urandom_range(0, 15)));
         vectors++;
         if (obs_vec() !== exp_vec()) begin
            $display("FAIL fly_frame1[%0d]: got %h want %h", i, obs_vec(), exp_vec());
            miscompares++;
         end
      end
      for (int i = 0; i < 11; i++) begin
         if (i >= 4 && i < 7) cyc(1'b0, 1'b1, 4'h0);
         else cyc(1'b1, 1'b0, 4'hF);
         vectors++;
         if (obs_vec() !== exp_vec()) begin
            $display("FAIL fly_frame2[%0d]: got %h want %h", i, obs_vec(), exp_vec());
            miscompares++;
         end
      end
      vectors++;
      if ({o4, o1, fv4} !== {32'hFFFF_FFFF, 8'hFF, 1'b1}) begin
         $display("FAIL fly_publish: got o4=%h o1=%h fv=%b want FFFFFFFF FF 1", o4, o1, fv4);
         miscompares++;
      end
   endtask

   task automatic test_misaligned();
      for (int i = 0; i < 13; i++) begin
         if (i < 5) cyc(1'b1, (i == 0), 4'h3);
         else if (i == 5) cyc(1'b1, 1'b1, 4'h1);
         else cyc(1'b1, 1'b0, 4'h0);
         vectors++;
         if (obs_vec() !== exp_vec()) begin
            $display("FAIL misaligned[%0d]: got %h want %h", i, obs_vec(), exp_vec());
            miscompares++;
         end
      end
      vectors++;
      if ({o4, o1, fv1} !== {32'h0000_0001, 8'h01, 1'b1}) begin
         $display("FAIL misaligned_publish: got o4=%h o1=%h fv=%b want 00000001 01 1",
                  o4, o1, fv1);
         miscompares++;
      end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 4; i++) cyc(1'b1, (i == 0), 4'($urandom_range(0, 15)));
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      vectors++;
      if (obs_vec() !== exp_vec()) begin
         $display("FAIL async_reset: got %h want %h", obs_vec(), exp_vec());
         miscompares++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         cyc(1'b1, (i == 4), 4'($urandom_range(0, 15)));
         vectors++;
         if (obs_vec() !== exp_vec()) begin
            $display("FAIL post_reset[%0d]: got %h want %h", i, obs_vec(), exp_vec());
            miscompares++;
         end
      end
   endtask

   task automatic test_w4();
      for (int i = 0; i < 8; i++) cyc(1'b1, (i == 0), 4'(i));
      vectors++;
      if ({o4, fv4} !== {32'h7654_3210, 1'b1}) begin
         $display("FAIL w4_publish: got o4=%h fv=%b want 76543210 1", o4, fv4);
         miscompares++;
      end
      cyc(1'b1, 1'b0, 4'h9);
      vectors++;
      if (obs_vec() !== exp_vec()) begin
         $display("FAIL w4_single_pulse: got %h want %h", obs_vec(), exp_vec());
         miscompares++;
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 11) == 0),
             4'($urandom_range(0, 15)));
         vectors++;
         if (obs_vec() !== exp_vec()) begin
            $display("FAIL random[%0d]: got %h want %h", i, obs_vec(), exp_vec());
            miscompares++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_flywheel();
      test_misaligned();
      test_async_reset();
      test_w4();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
